// File: rtl/a_pkg.sv
// ---------------------------------------------------------------------------
// a_pkg : shared states, field widths and beat-count helper for a_field_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package a_pkg;

  typedef enum logic [1:0] {
    S_D1  = 2'd0,
    S_D2  = 2'd1,
    S_D3  = 2'd2,
    S_PAR = 2'd3
  } state_t;

  localparam int G_WIN_DEF = 8;
  localparam int G_W1_DEF  = 8;
  localparam int G_W2_DEF  = 32;
  localparam int G_W3_DEF  = 16;

  localparam int D2_W_DEF  = G_W2_DEF + 2;
  localparam int D3_W_DEF  = G_W3_DEF * 2;

  function automatic int d2_width(input int w2);
    return w2 + 2;
  endfunction

  function automatic int d3_width(input int w3);
    return w3 * 2;
  endfunction

  function automatic int beats(input int w, input int win);
    return (w + win - 1) / win;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/a_field_acc.sv
// ---------------------------------------------------------------------------
// a_field_acc : W-bit shadow register filled LSB-first one beat at a time
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module a_field_acc #(
  parameter int W   = 8,
  parameter int WIN = 8,
  parameter int IW  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [IW-1:0]  idx,
  input  logic [WIN-1:0] data,
  output logic [W-1:0]   nxt
);

  logic [W-1:0] r_val;

  // nxt is the register value with this cycle's beat merged in, so the
  // top can commit a field in the same edge its last beat arrives.
  always_comb begin
    nxt = clr ? '0 : r_val;
    for (int j = 0; j < W; j++) begin
      if (wr_en && (idx == IW'(j / WIN))) begin
        nxt[j] = data[j % WIN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val <= '0;
    end else begin
      r_val <= nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/a_field_loader.sv
// ---------------------------------------------------------------------------
// a_field_loader : beat stream -> atomic d1/d2/d3 frame; optional parity beat
//                  enabled by A_FIELD_LOADER_PARITY_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module a_field_loader
  import a_pkg::*;
#(
  parameter int G_WIN = G_WIN_DEF,
  parameter int G_W1  = G_W1_DEF,
  parameter int G_W2  = G_W2_DEF,
  parameter int G_W3  = G_W3_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [G_WIN-1:0]  in_data,
  output logic [G_W1-1:0]   d1,
  output logic [G_W2+1:0]   d2,
  output logic [G_W3*2-1:0] d3,
  output logic              frm_valid,
  output logic              frm_err
);

  localparam int W2F  = d2_width(G_W2);
  localparam int W3F  = d3_width(G_W3);
  localparam int N1   = beats(G_W1, G_WIN);
  localparam int N2   = beats(W2F, G_WIN);
  localparam int N3   = beats(W3F, G_WIN);
  localparam int NMAX = max3(N1, N2, N3);
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  state_t          r_state, w_nxt_state;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic [CW-1:0]   w_idx1;
  logic            w_acc, w_start, w_partial;
  logic            w_we1, w_we2, w_we3, w_clr;
  logic            w_commit, w_err;
  logic [G_W1-1:0] w_sh1;
  logic [W2F-1:0]  w_sh2;
  logic [W3F-1:0]  w_sh3;

  assign in_ready  = rst_n;
  assign w_acc     = in_valid & in_ready;
  assign w_start   = w_acc & in_sof;
  assign w_partial = (r_state != S_D1) || (r_cnt != '0);

  a_field_acc #(.W(G_W1), .WIN(G_WIN), .IW(CW)) u_acc1 (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .wr_en(w_we1),
    .idx(w_idx1), .data(in_data), .nxt(w_sh1)
  );

  a_field_acc #(.W(W2F), .WIN(G_WIN), .IW(CW)) u_acc2 (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .wr_en(w_we2),
    .idx(r_cnt), .data(in_data), .nxt(w_sh2)
  );

  a_field_acc #(.W(W3F), .WIN(G_WIN), .IW(CW)) u_acc3 (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .wr_en(w_we3),
    .idx(r_cnt), .data(in_data), .nxt(w_sh3)
  );

`ifdef A_FIELD_LOADER_PARITY_EN
  logic w_par;
  assign w_par = ^{w_sh1, w_sh2, w_sh3};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_D1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_idx1      = r_cnt;
    w_we1       = 1'b0;
    w_we2       = 1'b0;
    w_we3       = 1'b0;
    w_clr       = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    if (w_start) begin
      // SOF always restarts: this beat becomes beat 0 of d1.
      w_clr  = 1'b1;
      w_we1  = 1'b1;
      w_idx1 = '0;
      w_err  = w_partial;
      if (N1 == 1) begin
        w_nxt_state = S_D2;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_state = S_D1;
        w_nxt_cnt   = CW'(1);
      end
    end else if (w_acc) begin
      case (r_state)
        S_D1: begin
          w_we1 = 1'b1;
          if (r_cnt == CW'(N1 - 1)) begin
            w_nxt_state = S_D2;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CW'(1);
          end
        end
        S_D2: begin
          w_we2 = 1'b1;
          if (r_cnt == CW'(N2 - 1)) begin
            w_nxt_state = S_D3;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CW'(1);
          end
        end
        S_D3: begin
          w_we3 = 1'b1;
          if (r_cnt == CW'(N3 - 1)) begin
            w_nxt_cnt = '0;
`ifdef A_FIELD_LOADER_PARITY_EN
            w_nxt_state = S_PAR;
`else
            w_nxt_state = S_D1;
            w_commit    = 1'b1;
`endif
          end else begin
            w_nxt_cnt = r_cnt + CW'(1);
          end
        end
        default: begin
`ifdef A_FIELD_LOADER_PARITY_EN
          if (in_data[0] == w_par) begin
            w_commit = 1'b1;
          end else begin
            w_err = 1'b1;
          end
`endif
          w_nxt_state = S_D1;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      frm_valid <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      frm_valid <= w_commit;
      frm_err   <= w_err;
      if (w_commit) begin
        d1 <= w_sh1;
        d2 <= w_sh2;
        d3 <= w_sh3;
      end
    end
  end

endmodule

`default_nettype wire
